game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl_pkg.sv | 29 ++
 rtl/game_ctrl_frame_timer.sv | 42 ++++
 rtl/game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_ctrl_pkg.sv
// Shared constants for the game controller: state encodings, default frame
// counts and the player start position.
package game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_NEXT_WAVE = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int FRAME_CNT_W               = 8;
    localparam int BLINK_BIT                 = 3;
    localparam int DEFAULT_START_LIVES       = 3;
    localparam int DEFAULT_RESPAWN_FRAMES    = 120;
    localparam int DEFAULT_WAVE_PAUSE_FRAMES = 60;
    localparam int DEFAULT_MAX_LEVEL         = 15;

    localparam logic [9:0] PLAYER_START_X = 10'd312;
    localparam logic [9:0] PLAYER_START_Y = 10'd440;

    // Wave number advance, saturating at the top level.
    function automatic logic [3:0] next_level(input logic [3:0] lvl,
                                              input logic [3:0] max_lvl);
        return (lvl >= max_lvl) ? max_lvl : lvl + 4'd1;
    endfunction

endpackage

// File: rtl/game_ctrl_frame_timer.sv
// Frame counter: counts frame pulses, clears synchronously, flags the frame
// pulse on which the count equals the terminal value.
module frame_timer
    import game_ctrl_pkg::*;
#(
    parameter int W       = FRAME_CNT_W,
    parameter int BIT_SEL = BLINK_BIT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         frame,
    input  logic [W-1:0] tc_value,
    output logic         tc,
    output logic         count_bit_next
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (frame) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc             = frame && (count_q == tc_value);
    // Next-cycle value so a registered consumer lines up with the count.
    assign count_bit_next = count_d[BIT_SEL];

endmodule

// File: rtl/game_ctrl.sv
// Top-level game sequencer: start/play/hit/next-wave/game-over flow with
// lives, level and registered control pulses for player and alien logic.
module game_ctrl
    import game_ctrl_pkg::*;
#(
    parameter int START_LIVES       = DEFAULT_START_LIVES,
    parameter int RESPAWN_FRAMES    = DEFAULT_RESPAWN_FRAMES,
    parameter int WAVE_PAUSE_FRAMES = DEFAULT_WAVE_PAUSE_FRAMES,
    parameter int MAX_LEVEL         = DEFAULT_MAX_LEVEL
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame,
    input  logic       start,
    input  logic       player_hit,
    input  logic       aliens_cleared,
    input  logic       aliens_landed,
    output logic [2:0] state,
    output logic       player_arst,
    output logic       wave_rst,
    output logic       move_en,
    output logic [1:0] lives,
    output logic [3:0] level,
    output logic       blink
);

    state_t     state_q, state_d;
    logic [1:0] lives_q, lives_d;
    logic [3:0] level_q, level_d;
    logic       player_arst_q, player_arst_d;
    logic       wave_rst_q, wave_rst_d;
    logic       move_en_q, move_en_d;
    logic       blink_q, blink_d;
    logic       start_q, start_d;

    logic                   start_edge;
    logic                   timer_clr;
    logic                   timer_tc;
    logic                   timer_bit_next;
    logic [FRAME_CNT_W-1:0] tc_value;

    assign start_d    = start;
    assign start_edge = start && !start_q;

    frame_timer #(
        .W       (FRAME_CNT_W),
        .BIT_SEL (BLINK_BIT)
    ) u_frame_timer (
        .clk            (clk),
        .rst            (rst),
        .clr            (timer_clr),
        .frame          (frame),
        .tc_value       (tc_value),
        .tc             (timer_tc),
        .count_bit_next (timer_bit_next)
    );

    // Terminal value depends only on the current state, so tc never loops
    // back through the next-state logic.
    always_comb begin
        tc_value = '0;
        case (state_q)
            ST_HIT:       tc_value = FRAME_CNT_W'(RESPAWN_FRAMES - 1);
            ST_NEXT_WAVE: tc_value = FRAME_CNT_W'(WAVE_PAUSE_FRAMES - 1);
            default:      tc_value = '0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        lives_d       = lives_q;
        level_d       = level_q;
        player_arst_d = 1'b0;
        wave_rst_d    = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge) begin
                    state_d       = ST_PLAY;
                    lives_d       = 2'(START_LIVES);
                    level_d       = 4'd0;
                    player_arst_d = 1'b1;
                    wave_rst_d    = 1'b1;
                end
            end

            ST_PLAY: begin
                if (aliens_landed) begin
                    state_d = ST_GAME_OVER;
                    lives_d = 2'd0;
                end else if (player_hit) begin
                    if (lives_q <= 2'd1) begin
                        state_d = ST_GAME_OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = ST_HIT;
                        lives_d = lives_q - 2'd1;
                    end
                end else if (aliens_cleared) begin
                    state_d = ST_NEXT_WAVE;
                end
            end

            ST_HIT: begin
                if (timer_tc) begin
                    state_d       = ST_PLAY;
                    player_arst_d = 1'b1;
                end
            end

            ST_NEXT_WAVE: begin
                if (timer_tc) begin
                    state_d    = ST_PLAY;
                    wave_rst_d = 1'b1;
                    level_d    = next_level(level_q, 4'(MAX_LEVEL));
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Any state change restarts the frame count for the state being entered.
    assign timer_clr = (state_d != state_q);
    assign move_en_d = (state_d == ST_PLAY);
    assign blink_d   = (state_d == ST_HIT) ? timer_bit_next : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            lives_q       <= 2'd0;
            level_q       <= 4'd0;
            player_arst_q <= 1'b1;
            wave_rst_q    <= 1'b0;
            move_en_q     <= 1'b0;
            blink_q       <= 1'b1;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            lives_q       <= lives_d;
            level_q       <= level_d;
            player_arst_q <= player_arst_d;
            wave_rst_q    <= wave_rst_d;
            move_en_q     <= move_en_d;
            blink_q       <= blink_d;
            start_q       <= start_d;
        end
    end

    assign state       = state_q;
    assign lives       = lives_q;
    assign level       = level_q;
    assign player_arst = player_arst_q;
    assign wave_rst    = wave_rst_q;
    assign move_en     = move_en_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: expected output snapshots are queued with each
// stimulus step and compared after the following clock edge.
module tb_game_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_HIT  = 3'd2;
    localparam logic [2:0] S_NW   = 3'd3;
    localparam logic [2:0] S_GO   = 3'd4;

    logic       clk;
    logic       rst;
    logic       frame;
    logic       start;
    logic       player_hit;
    logic       aliens_cleared;
    logic       aliens_landed;
    logic [2:0] state;
    logic       player_arst;
    logic       wave_rst;
    logic       move_en;
    logic [1:0] lives;
    logic [3:0] level;
    logic       blink;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
        logic [1:0] lv;
        logic [3:0] lvl;
        logic       mv;
        logic       arst;
        logic       wrst;
        logic       blk;
    } exp_t;

    exp_t sb_q[$];

    game_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .frame          (frame),
        .start          (start),
        .player_hit     (player_hit),
        .aliens_cleared (aliens_cleared),
        .aliens_landed  (aliens_landed),
        .state          (state),
        .player_arst    (player_arst),
        .wave_rst       (wave_rst),
        .move_en        (move_en),
        .lives          (lives),
        .level          (level),
        .blink          (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic expect_out(input string tag, input logic [2:0] st,
                              input logic [1:0] lv, input logic [3:0] lvl,
                              input logic mv, input logic arst,
                              input logic wrst, input logic blk);
        exp_t e;
        e.tag = tag; e.st = st; e.lv = lv; e.lvl = lvl;
        e.mv = mv; e.arst = arst; e.wrst = wrst; e.blk = blk;
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input string field,
                       input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s.%s: observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, "state",       {1'b0, state},   {1'b0, e.st});
            chk(e.tag, "lives",       {2'b0, lives},   {2'b0, e.lv});
            chk(e.tag, "level",       level,           e.lvl);
            chk(e.tag, "move_en",     {3'b0, move_en}, {3'b0, e.mv});
            chk(e.tag, "player_arst", {3'b0, player_arst}, {3'b0, e.arst});
            chk(e.tag, "wave_rst",    {3'b0, wave_rst},    {3'b0, e.wrst});
            chk(e.tag, "blink",       {3'b0, blink},   {3'b0, e.blk});
            $display("step %-20s state=%0d lives=%0d level=%0d move_en=%0b arst=%0b wrst=%0b blink=%0b",
                     e.tag, state, lives, level, move_en, player_arst, wave_rst, blink);
        end
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame = 1'b1;
            @(posedge clk); #1;
            frame = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [3:0] lvl;
        logic [3:0] nxt;

        rst = 1'b1; start = 1'b0; frame = 1'b0;
        player_hit = 1'b0; aliens_cleared = 1'b0; aliens_landed = 1'b0;

        #2;
        expect_out("reset_async", S_IDLE, 2'd0, 4'd0, 0, 1, 0, 1); drain();
        @(posedge clk); #1;
        expect_out("reset_held", S_IDLE, 2'd0, 4'd0, 0, 1, 0, 1); drain();
        rst = 1'b0;
        expect_out("after_reset", S_IDLE, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();

        aliens_landed = 1'b1;
        expect_out("idle_ignore", S_IDLE, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();
        aliens_landed = 1'b0;

        start = 1'b1;
        expect_out("start_play", S_PLAY, 2'd3, 4'd0, 1, 1, 1, 1); clk_step();
        start = 1'b0;
        expect_out("play_settle", S_PLAY, 2'd3, 4'd0, 1, 0, 0, 1); clk_step();

        player_hit = 1'b1;
        expect_out("hit_enter", S_HIT, 2'd2, 4'd0, 0, 0, 0, 0); clk_step();
        player_hit = 1'b0;
        frames(8);
        expect_out("hit_blink8", S_HIT, 2'd2, 4'd0, 0, 0, 0, 1); drain();
        player_hit = 1'b1; aliens_landed = 1'b1; aliens_cleared = 1'b1;
        expect_out("hit_ignore", S_HIT, 2'd2, 4'd0, 0, 0, 0, 1); clk_step();
        player_hit = 1'b0; aliens_landed = 1'b0; aliens_cleared = 1'b0;
        frames(111);
        expect_out("hit_119", S_HIT, 2'd2, 4'd0, 0, 0, 0, 0); drain();
        frame = 1'b1;
        expect_out("respawn", S_PLAY, 2'd2, 4'd0, 1, 1, 0, 1); clk_step();
        frame = 1'b0;
        expect_out("respawn_end", S_PLAY, 2'd2, 4'd0, 1, 0, 0, 1); clk_step();

        player_hit = 1'b1; aliens_cleared = 1'b1;
        expect_out("prio_hit_clear", S_HIT, 2'd1, 4'd0, 0, 0, 0, 0); clk_step();
        player_hit = 1'b0; aliens_cleared = 1'b0;
        frames(120);
        expect_out("respawn2", S_PLAY, 2'd1, 4'd0, 1, 0, 0, 1); drain();

        start = 1'b1;
        expect_out("start_in_play", S_PLAY, 2'd1, 4'd0, 1, 0, 0, 1); clk_step();
        player_hit = 1'b1;
        expect_out("last_life", S_GO, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();
        player_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_out("held_start", S_GO, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();
        end
        aliens_cleared = 1'b1;
        expect_out("go_ignore", S_GO, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();
        aliens_cleared = 1'b0;
        start = 1'b0;
        expect_out("start_release", S_GO, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();
        start = 1'b1;
        expect_out("restart", S_PLAY, 2'd3, 4'd0, 1, 1, 1, 1); clk_step();
        start = 1'b0;
        expect_out("restart_settle", S_PLAY, 2'd3, 4'd0, 1, 0, 0, 1); clk_step();

        for (int w = 0; w < 16; w++) begin
            lvl = 4'(w);
            nxt = (w >= 15) ? 4'd15 : 4'(w + 1);
            aliens_cleared = 1'b1;
            expect_out("wave_enter", S_NW, 2'd3, lvl, 0, 0, 0, 1); clk_step();
            aliens_cleared = 1'b0;
            if (w == 0) begin
                player_hit = 1'b1; aliens_landed = 1'b1;
                expect_out("nw_ignore", S_NW, 2'd3, lvl, 0, 0, 0, 1); clk_step();
                player_hit = 1'b0; aliens_landed = 1'b0;
            end
            frames(59);
            expect_out("wave_59", S_NW, 2'd3, lvl, 0, 0, 0, 1); drain();
            frame = 1'b1;
            expect_out("wave_done", S_PLAY, 2'd3, nxt, 1, 0, 1, 1); clk_step();
            frame = 1'b0;
            expect_out("wave_settle", S_PLAY, 2'd3, nxt, 1, 0, 0, 1); clk_step();
        end

        aliens_landed = 1'b1; player_hit = 1'b1;
        expect_out("landed_prio", S_GO, 2'd0, 4'd15, 0, 0, 0, 1); clk_step();
        aliens_landed = 1'b0; player_hit = 1'b0;

        start = 1'b1;
        expect_out("restart2", S_PLAY, 2'd3, 4'd0, 1, 1, 1, 1); clk_step();
        start = 1'b0;
        player_hit = 1'b1;
        expect_out("hit_again", S_HIT, 2'd2, 4'd0, 0, 0, 0, 0); clk_step();
        player_hit = 1'b0;
        frames(50);
        expect_out("hit_50", S_HIT, 2'd2, 4'd0, 0, 0, 0, 0); drain();
        rst = 1'b1;
        #1;
        expect_out("rst_mid_hit", S_IDLE, 2'd0, 4'd0, 0, 1, 0, 1); drain();
        @(posedge clk); #1;
        expect_out("rst_mid_hit_held", S_IDLE, 2'd0, 4'd0, 0, 1, 0, 1); drain();
        rst = 1'b0;
        expect_out("post_rst", S_IDLE, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();
        expect_out("post_rst_idle", S_IDLE, 2'd0, 4'd0, 0, 0, 0, 1); clk_step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
